if_stage: RTL

- Pipeline stage 1: PC generation and instruction fetch.
- Receiving end of the ID→IF redirect bus: br_taken_cancel plus PC_fromID.
- Issues word reads to a synchronous inst SRAM (1-cycle read latency).
- Hands {pred_PC, inst_PC, inst} to IPD using the valid/allow_in handshake.
- Contains a one-entry instruction hold buffer so SRAM data survives IPD stalls.

---
 rtl/if_stage_pkg.sv | 18 +
 rtl/if_inst_hold_buf.sv | 41 ++++
 rtl/if_stage.sv | 87 ++++++++
 3 files changed

// File: rtl/if_stage_pkg.sv
// Shared widths, reset address and bus layout for the instruction-fetch stage.
package if_stage_pkg;

    localparam int          IF_TO_IPD_BUS_WD = 96;
    localparam int          ID_TO_IF_BUS_WD  = 33;
    localparam logic [31:0] RESET_PC_VALUE   = 32'h1C00_0000;

    typedef struct packed {
        logic [31:0] pred_pc;
        logic [31:0] inst_pc;
        logic [31:0] inst;
    } if_to_ipd_t;

    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/if_inst_hold_buf.sv
// One-entry holding register that keeps the SRAM read word alive while IPD stalls.
module if_inst_hold_buf (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear_i,
    input  logic        rsp_fresh_i,
    input  logic        if_valid_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] inst_o,
    output logic        buf_valid_o
);

    logic        buf_valid_q, buf_valid_d;
    logic [31:0] buf_inst_q, buf_inst_d;

    always_comb begin
        buf_valid_d = buf_valid_q;
        buf_inst_d  = buf_inst_q;
        if (clear_i) begin
            buf_valid_d = 1'b0;
        end else if (rsp_fresh_i && if_valid_i && !buf_valid_q) begin
            // last chance: the SRAM output is undefined once no request follows
            buf_valid_d = 1'b1;
            buf_inst_d  = rdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            buf_valid_q <= 1'b0;
            buf_inst_q  <= 32'h0;
        end else begin
            buf_valid_q <= buf_valid_d;
            buf_inst_q  <= buf_inst_d;
        end
    end

    assign inst_o      = buf_valid_q ? buf_inst_q : rdata_i;
    assign buf_valid_o = buf_valid_q;

endmodule

// File: rtl/if_stage.sv
// Pipeline stage 1: PC generation, inst SRAM request and hand-off to IPD.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_VALUE
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [ID_TO_IF_BUS_WD-1:0]  ID_to_IF_bus,
    input  logic                        IPD_allow_in,
    output logic                        IF_to_IPD_valid,
    output logic [IF_TO_IPD_BUS_WD-1:0] IF_to_IPD_bus,
    output logic                        inst_sram_en,
    output logic [3:0]                  inst_sram_we,
    output logic [31:0]                 inst_sram_addr,
    output logic [31:0]                 inst_sram_wdata,
    input  logic [31:0]                 inst_sram_rdata
);

    logic        br_taken_cancel;
    logic [31:0] pc_from_id;
    logic        if_ready_go;
    logic        if_allow_in;
    logic [31:0] nextpc;
    logic [31:0] inst;
    logic        buf_valid;
    if_to_ipd_t  bus;

    logic        if_valid_q, if_valid_d;
    logic [31:0] if_pc_q, if_pc_d;
    logic        rsp_fresh_q, rsp_fresh_d;

    assign br_taken_cancel = ID_to_IF_bus[32];
    assign pc_from_id      = ID_to_IF_bus[31:0];

    // a cancel always opens IF so the redirect target is fetched immediately
    assign if_ready_go = 1'b1;
    assign if_allow_in = ~if_valid_q | (if_ready_go & IPD_allow_in) | br_taken_cancel;
    assign nextpc      = br_taken_cancel ? pc_from_id : pc_plus4(if_pc_q);

    always_comb begin
        if_valid_d  = if_valid_q;
        if_pc_d     = if_pc_q;
        rsp_fresh_d = 1'b0;
        if (if_allow_in) begin
            if_valid_d  = 1'b1;
            if_pc_d     = nextpc;
            rsp_fresh_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            if_valid_q  <= 1'b0;
            if_pc_q     <= RESET_PC - 32'd4;
            rsp_fresh_q <= 1'b0;
        end else begin
            if_valid_q  <= if_valid_d;
            if_pc_q     <= if_pc_d;
            rsp_fresh_q <= rsp_fresh_d;
        end
    end

    if_inst_hold_buf u_hold_buf (
        .clk         (clk),
        .reset       (reset),
        .clear_i     (if_allow_in),
        .rsp_fresh_i (rsp_fresh_q),
        .if_valid_i  (if_valid_q),
        .rdata_i     (inst_sram_rdata),
        .inst_o      (inst),
        .buf_valid_o (buf_valid)
    );

    assign inst_sram_en    = ~reset & if_allow_in;
    assign inst_sram_we    = 4'h0;
    assign inst_sram_addr  = {nextpc[31:2], 2'b00};
    assign inst_sram_wdata = 32'h0;

    assign bus.pred_pc = pc_plus4(if_pc_q);
    assign bus.inst_pc = if_pc_q;
    assign bus.inst    = inst;

    assign IF_to_IPD_valid = if_valid_q & ~br_taken_cancel;
    assign IF_to_IPD_bus   = bus;

endmodule
